// File: rtl/arbitro_ula_if.sv
// Bus bundle between the control side (two requesters plus response consumer)
// and the ALU arbiter. The arbiter takes the slave view, the environment the master view.
interface arbitro_ula_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;

  logic [DATA_W-1:0] ula_entrada1;
  logic [DATA_W-1:0] ula_entrada2;
  logic [OP_W-1:0]   ula_sinal;
  logic [DATA_W-1:0] ula_saida;
  logic              ula_zero;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_dado;
  logic              resp_zero;
  logic              resp_op_inv;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output ula_entrada1, ula_entrada2, ula_sinal,
    input  ula_saida, ula_zero,
    output resp_valid, resp_id, resp_dado, resp_zero, resp_op_inv,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  ula_entrada1, ula_entrada2, ula_sinal,
    output ula_saida, ula_zero,
    input  resp_valid, resp_id, resp_dado, resp_zero, resp_op_inv,
    output resp_ready
  );
endinterface

// File: rtl/arbitro_ula.sv
// Two-requester arbiter in front of a single shared 8-bit ALU.
// One operation in flight: grant and register operands, let the ALU settle for
// one cycle, capture its result, then hold the tagged response until taken.
//
// state  | meaning
// OCIOSO | idle, grants a requester when any is valid
// EXEC   | registered operands drive the ALU, result captured at end of cycle
// RESP   | response held on resp_*, waits for resp_ready
module arbitro_ula #(
  parameter int DATA_W     = 8,
  parameter int OP_W       = 3,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 4
) (
  input logic           clock,
  input logic           reset,
  arbitro_ula_if.slave  bus
);

  typedef enum logic [1:0] {OCIOSO, EXEC, RESP} estado_t;

  localparam logic [3:0]      MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [OP_W-1:0] OP_MAX_C   = OP_W'(4);

  estado_t           estado_q;
  logic              last_q, last_d;
  logic [3:0]        wait_q, wait_d;
  logic [DATA_W-1:0] ent1_q, ent2_q, dado_q;
  logic [OP_W-1:0]   sinal_q;
  logic              resp_valid_q, resp_id_q, resp_zero_q, resp_op_inv_q;

  logic              grant_any;
  logic              grant_sel;
  logic              can_grant;

  // Pick the winner among valid requesters and compute the arbitration history update.
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    grant_sel = 1'b0;
    last_d    = last_q;
    wait_d    = wait_q;
    if (bus.req0_valid && bus.req1_valid) begin
      if (FIXED_PRIO != 0) grant_sel = (wait_q >= MAX_WAIT_C);
      else                 grant_sel = ~last_q;
    end else begin
      grant_sel = bus.req1_valid;
    end
    if (grant_any) begin
      last_d = grant_sel;
      if (FIXED_PRIO != 0) begin
        if (grant_sel)                                 wait_d = 4'd0;
        else if (bus.req1_valid && wait_q != 4'hF)     wait_d = wait_q + 4'd1;
      end
    end
  end

  // Ready is only offered while idle and out of reset, to the winner alone.
  assign can_grant      = (estado_q == OCIOSO) && !reset && grant_any;
  assign bus.req0_ready = can_grant & ~grant_sel;
  assign bus.req1_ready = can_grant &  grant_sel;

  // Sequencer: grant/capture operands, capture ALU result, hold response.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q      <= OCIOSO;
      last_q        <= 1'b1;
      wait_q        <= 4'd0;
      ent1_q        <= '0;
      ent2_q        <= '0;
      sinal_q       <= '0;
      dado_q        <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_zero_q   <= 1'b0;
      resp_op_inv_q <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (grant_any) begin
            ent1_q    <= grant_sel ? bus.req1_a  : bus.req0_a;
            ent2_q    <= grant_sel ? bus.req1_b  : bus.req0_b;
            sinal_q   <= grant_sel ? bus.req1_op : bus.req0_op;
            resp_id_q <= grant_sel;
            last_q    <= last_d;
            wait_q    <= wait_d;
            estado_q  <= EXEC;
          end
        end
        EXEC: begin
          dado_q        <= bus.ula_saida;
          resp_zero_q   <= bus.ula_zero;
          resp_op_inv_q <= (sinal_q > OP_MAX_C);
          resp_valid_q  <= 1'b1;
          estado_q      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            estado_q     <= OCIOSO;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign bus.ula_entrada1 = ent1_q;
  assign bus.ula_entrada2 = ent2_q;
  assign bus.ula_sinal    = sinal_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_dado    = dado_q;
  assign bus.resp_zero    = resp_zero_q;
  assign bus.resp_op_inv  = resp_op_inv_q;

endmodule
